shift_right_seq: RTL and testbench

Iterative right-shift unit for the 24-bit datapath, covering the shift-right operations (logical and arithmetic) that complement the existing combinational left shifter. It shifts one bit position per clock under a start/busy/done handshake, trading latency for area. It sits beside the ALU and is driven by the execute-stage controller, which stalls on `busy`.

---
 rtl/shift_right_seq_if.sv | 23 ++
 rtl/shift_right_seq.sv | 83 ++++++++
 tb/tb_shift_right_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/shift_right_seq_if.sv
// Request/result bundle for the iterative right shifter.
// The execute-stage controller is the master; the shifter is the slave.
interface shift_right_seq_if #(
    parameter int unsigned WIDTH = 24
);
    logic             start;
    logic             arith;
    logic [WIDTH-1:0] tbsh;
    logic [WIDTH-1:0] s;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sh;

    modport master (
        output start, arith, tbsh, s,
        input  busy, done, sh
    );

    modport slave (
        input  start, arith, tbsh, s,
        output busy, done, sh
    );
endinterface

// File: rtl/shift_right_seq.sv
// Iterative logical/arithmetic right shifter.
// Moves one bit position per clock and signals completion with a one-cycle done pulse.
module shift_right_seq #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_right_seq_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             fill_q,  fill_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] amt_c;

    // Any amount of WIDTH or more saturates; all bits of s take part in the compare.
    assign amt_c = (bus.s >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(bus.s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.tbsh;
                    cnt_d   = amt_c;
                    fill_d  = bus.arith & bus.tbsh[WIDTH-1];
                    state_d = (amt_c == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = {fill_q, work_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are flopped alongside the state so they carry no input-to-output path.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sh   = work_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// Directed and randomized checks of the iterative right shifter:
// results, latency, busy length, done pulse width, ignored starts and reset abort.
module tb_shift_right_seq;
    localparam int unsigned WIDTH = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_right_seq_if #(.WIDTH(WIDTH)) bus ();
    shift_right_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bit-by-bit reference: result bit i comes from operand bit i+n, else the fill bit.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                   input int n, input logic fill);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++)
            r[i] = (i + n < int'(WIDTH)) ? a[i+n] : fill;
        return r;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] amt,
                          input logic ar, input logic [WIDTH-1:0] exp_sh,
                          input int exp_n, input string tag);
        int k;
        int busy_cnt;
        @(negedge clk);
        bus.tbsh  = a;
        bus.s     = amt;
        bus.arith = ar;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.tbsh  = WIDTH'($urandom);
        bus.s     = WIDTH'($urandom);
        bus.arith = 1'($urandom);
        k = 0;
        busy_cnt = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 32'(k + 1), 32'(exp_n + 1));
        check({tag, "_busycyc"}, 32'(busy_cnt), 32'(exp_n));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_sh"}, 32'(bus.sh), 32'(exp_sh));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_sh_hold"}, 32'(bus.sh), 32'(exp_sh));
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;
        logic [WIDTH-1:0] done_sh;
        logic [WIDTH-1:0] ra, rs;
        logic rar;
        int rn;

        bus.start = 1'b0;
        bus.arith = 1'b0;
        bus.tbsh  = '0;
        bus.s     = '0;
        rst_n     = 1'b0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sh",   32'(bus.sh),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_sh",   32'(bus.sh),   32'd0);

        run_op(24'h800F00, 24'd4, 1'b0, 24'h0800F0, 4, "logical4");

        // Asynchronous reset mid-cycle clears outputs before any edge.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sh",   32'(bus.sh),   32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(24'h900000, 24'h000100, 1'b1, 24'hFFFFFF, 24, "arith_sat");
        run_op(24'h900000, 24'h000100, 1'b0, 24'h000000, 24, "logic_sat");
        run_op(24'h123456, 24'd0,      1'b0, 24'h123456, 0,  "zero");
        run_op(24'h7FFFFF, 24'd23,     1'b1, 24'h000000, 23, "arith_pos23");
        run_op(24'h800000, 24'd23,     1'b1, 24'hFFFFFF, 23, "arith_neg23");
        run_op(24'hC00000, 24'd24,     1'b1, 24'hFFFFFF, 24, "arith_exact24");
        run_op(24'h000003, 24'd1,      1'b0, 24'h000001, 1,  "one");
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'h000000, 24, "huge_s");

        // A start pulse during an operation is ignored.
        @(negedge clk);
        bus.tbsh = 24'hABCDEF; bus.s = 24'd10; bus.arith = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; first_done = -1; done_sh = '0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin
                bus.tbsh = 24'h000001; bus.s = 24'd1; bus.arith = 1'b0; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                if (first_done < 0) begin first_done = k; done_sh = bus.sh; end
            end
            @(posedge clk); #1;
        end
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_latency", 32'(first_done), 32'd10);
        check("ign_sh", 32'(done_sh), 32'hFFEAF3);

        // Reset in the middle of an operation aborts it without a done.
        @(negedge clk);
        bus.tbsh = 24'h00FF00; bus.s = 24'd8; bus.arith = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sh",   32'(bus.sh),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_sh_after", 32'(bus.sh), 32'd0);
        run_op(24'hFF0000, 24'd16, 1'b0, 24'h0000FF, 16, "post_abort");

        // Start held high re-triggers every n+2 cycles.
        @(negedge clk);
        bus.tbsh = 24'h000008; bus.s = 24'd2; bus.arith = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        first_done = -1; second_done = -1; done_sh = '0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) begin
                if (first_done < 0) begin first_done = k; done_sh = bus.sh; end
                else if (second_done < 0) second_done = k;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("held_first_done", 32'(first_done), 32'd2);
        check("held_period", 32'(second_done - first_done), 32'd4);
        check("held_sh", 32'(done_sh), 32'h000002);

        for (int i = 0; i < 1000; i++) begin
            ra  = WIDTH'($urandom);
            rar = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rs = WIDTH'($urandom);
            else rs = WIDTH'($urandom_range(0, 30));
            rn = (rs >= WIDTH'(WIDTH)) ? int'(WIDTH) : int'(rs);
            run_op(ra, rs, rar, ref_shift(ra, rn, rar & ra[WIDTH-1]), rn,
                   $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
